ram_1r1w_init: RTL and testbench

RAM_1R1W_INIT -- requirements
Module: ram_1r1w_init

---
 rtl/ram_1r1w_pkg.sv | 34 +++
 rtl/ram_1r1w_array.sv | 37 +++
 rtl/ram_1r1w_init.sv | 138 +++++++++++++
 tb/tb_ram_1r1w_init.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_1r1w_pkg.sv
// Shared types and helpers for the 1R1W initialising RAM.
// The lane-merge helper works on a fixed maximum width so any instance size can call it.
`timescale 1ns/1ps
package ram_1r1w_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int MAX_DATA_W = 1024;
    localparam int MAX_MASK_W = MAX_DATA_W;
    localparam int IDX_W      = $clog2(MAX_DATA_W);

    // Per-lane select: bits of lanes whose mask bit is set come from new_data.
    function automatic logic [MAX_DATA_W-1:0] lane_merge(
        input logic [MAX_DATA_W-1:0] old_data,
        input logic [MAX_DATA_W-1:0] new_data,
        input logic [MAX_MASK_W-1:0] mask,
        input int                    lane_w
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_data;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            int lane;
            lane = i / lane_w;
            if (mask[IDX_W'(lane)]) begin
                merged[IDX_W'(i)] = new_data[IDX_W'(i)];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_1r1w_array.sv
// Plain one-read one-write storage array with per-lane write enables.
// Asynchronous read port; contents carry no reset.
`timescale 1ns/1ps
module ram_1r1w_array
    import ram_1r1w_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10,
    parameter int MASK_W = 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [MASK_W-1:0] wr_mask,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int LANE_W = DATA_W / MASK_W;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < MASK_W; l++) begin
                if (wr_mask[l]) begin
                    mem[wr_addr][l*LANE_W +: LANE_W] <= wr_data[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ram_1r1w_init.sv
// 1R1W RAM that sweeps INIT_VAL through every entry after reset or on init_req.
// Define RAM_1R1W_BYPASS_EN to forward same-address write data to the read port.
`timescale 1ns/1ps
module ram_1r1w_init
    import ram_1r1w_pkg::*;
#(
    parameter int                DATA_W   = 128,
    parameter int                ADDR_W   = 10,
    parameter int                MASK_W   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              init_req,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [MASK_W-1:0] w_mask,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              init_busy
);

    if (DATA_W % MASK_W != 0) begin : g_bad_mask_w
        $error("ram_1r1w_init: DATA_W must be a multiple of MASK_W");
    end

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // init_req is only honoured from READY; a request mid-sweep is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (init_req) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign ready     = (state_q == READY);
    assign init_busy = !ready;

    // p0: array access; the sweep owns the write port while busy
    logic              arr_wr_en;
    logic [ADDR_W-1:0] arr_wr_addr;
    logic [DATA_W-1:0] arr_wr_data;
    logic [MASK_W-1:0] arr_wr_mask;
    logic [DATA_W-1:0] rd_raw_p0;
    logic [DATA_W-1:0] rd_next_p0;

    assign arr_wr_en   = ready ? w_en   : 1'b1;
    assign arr_wr_addr = ready ? w_addr : cnt_q;
    assign arr_wr_data = ready ? w_data : INIT_VAL;
    assign arr_wr_mask = ready ? w_mask : {MASK_W{1'b1}};

    ram_1r1w_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .MASK_W (MASK_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_wr_en),
        .wr_addr (arr_wr_addr),
        .wr_data (arr_wr_data),
        .wr_mask (arr_wr_mask),
        .rd_addr (r_addr),
        .rd_data (rd_raw_p0)
    );

`ifdef RAM_1R1W_BYPASS_EN
    localparam int LANE_W = DATA_W / MASK_W;

    if (DATA_W > MAX_DATA_W) begin : g_bad_data_w
        $error("ram_1r1w_init: DATA_W exceeds lane_merge width");
    end

    logic same_addr_p0;

    assign same_addr_p0 = w_en && (w_addr == r_addr);
    assign rd_next_p0   = same_addr_p0
                        ? DATA_W'(lane_merge(MAX_DATA_W'(rd_raw_p0), MAX_DATA_W'(w_data),
                                             MAX_MASK_W'(w_mask), LANE_W))
                        : rd_raw_p0;
`else
    // The array read is combinational, so it still shows pre-write contents.
    assign rd_next_p0 = rd_raw_p0;
`endif

    // p1: registered read port
    logic [DATA_W-1:0] rd_data_p1;
    logic              rd_vld_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_p1  <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            rd_vld_p1 <= ready && r_en;
            if (ready && r_en) begin
                rd_data_p1 <= rd_next_p0;
            end
        end
    end

    assign r_data  = rd_data_p1;
    assign r_valid = rd_vld_p1;

endmodule

// File: tb/tb_ram_1r1w_init.sv
// Bench for ram_1r1w_init at DATA_W=32, ADDR_W=4, MASK_W=4, INIT_VAL=0.
// Honours RAM_1R1W_BYPASS_EN for the same-address read/write expectations.
`timescale 1ns/1ps
module tb_ram_1r1w_init;

    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 4;
    localparam int          MASK_W   = 4;
    localparam logic [31:0] INIT_VAL = 32'h0;
`ifdef RAM_1R1W_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        init_req;
    logic        w_en;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_mask;
    logic        r_en;
    logic [3:0]  r_addr;
    logic [31:0] r_data;
    logic        r_valid;
    logic        init_busy;

    ram_1r1w_init #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MASK_W   (MASK_W),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .init_req  (init_req),
        .w_en      (w_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .w_mask    (w_mask),
        .r_en      (r_en),
        .r_addr    (r_addr),
        .r_data    (r_data),
        .r_valid   (r_valid),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_data;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic        re;
        logic [3:0]  ra;
        logic        ev;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] wm, input logic re, input logic [3:0] ra,
                         input logic ir);
        w_en     = we;
        w_addr   = wa;
        w_data   = wd;
        w_mask   = wm;
        r_en     = re;
        r_addr   = ra;
        init_req = ir;
    endtask

    // One clock: queue the expected read result, then compare after the edge.
    task automatic step(input string name, input logic ev, input logic [31:0] ed);
        logic [31:0] e;
        if (ev) exp_q.push_back(ed);
        @(posedge clk);
        #1;
        check({name, " r_valid"}, 32'(r_valid), 32'(ev));
        if (r_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s unexpected: got r_valid=1 want no pending read", name);
            end else begin
                e = exp_q.pop_front();
                check({name, " r_data"}, r_data, e);
                last_data = e;
            end
        end else begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            check({name, " r_data hold"}, r_data, last_data);
        end
    endtask

    function automatic logic [31:0] pat(input int a);
        return 32'h01020304 + 32'(a) * 32'h11111111;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100us");
        $fatal(1);
    end

    initial begin
        int n;

        tbl[0]  = '{1'b1, 4'd3, 32'hAABBCCDD, 4'b0101, 1'b0, 4'd0,  1'b0, 32'h0};
        tbl[1]  = '{1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 4'd3,  1'b1, 32'h00BB00DD};
        tbl[2]  = '{1'b1, 4'd5, 32'h11111111, 4'b1111, 1'b0, 4'd0,  1'b0, 32'h0};
        tbl[3]  = '{1'b1, 4'd5, 32'h22222222, 4'b1111, 1'b1, 4'd5,  1'b1,
                    BYP ? 32'h22222222 : 32'h11111111};
        tbl[4]  = '{1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 4'd5,  1'b1, 32'h22222222};
        tbl[5]  = '{1'b1, 4'd7, 32'h12345678, 4'b1111, 1'b1, 4'd3,  1'b1, 32'h00BB00DD};
        tbl[6]  = '{1'b1, 4'd7, 32'hFFFFFFFF, 4'b0000, 1'b1, 4'd7,  1'b1, 32'h12345678};
        tbl[7]  = '{1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 4'd7,  1'b1, 32'h12345678};
        tbl[8]  = '{1'b1, 4'd7, 32'hA5A5A5A5, 4'b1010, 1'b1, 4'd7,  1'b1,
                    BYP ? 32'hA534A578 : 32'h12345678};
        tbl[9]  = '{1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 4'd7,  1'b1, 32'hA534A578};
        tbl[10] = '{1'b0, 4'd0, 32'h0,        4'b0000, 1'b0, 4'd0,  1'b0, 32'h0};
        tbl[11] = '{1'b1, 4'd0, 32'hCAFEF00D, 4'b1111, 1'b1, 4'd15, 1'b1, 32'h0};
        tbl[12] = '{1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 4'd0,  1'b1, 32'hCAFEF00D};
        tbl[13] = '{1'b1, 4'd9, 32'h0F0F0F0F, 4'b0001, 1'b1, 4'd9,  1'b1,
                    BYP ? 32'h0000000F : 32'h0};

        // Reset state
        reset_n   = 1'b0;
        last_data = 32'h0;
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst init_busy", 32'(init_busy), 32'h1);
        check("rst r_valid", 32'(r_valid), 32'h0);
        check("rst r_data", r_data, 32'h0);

        // Power-up sweep with user traffic that must be ignored
        drive(1'b1, 4'd1, 32'hDEADBEEF, 4'hF, 1'b1, 4'd1, 1'b0);
        reset_n = 1'b1;
        n = 0;
        while (init_busy && n < 100) begin
            n++;
            step("init", 1'b0, 32'h0);
        end
        check("init busy cycles", 32'(n), 32'd16);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0);

        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a), 1'b0);
            step("sweep0", 1'b1, INIT_VAL);
        end

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wm, tbl[i].re, tbl[i].ra, 1'b0);
            step($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed);
        end

        // Re-init request with a same-cycle write and read of addr 2
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 4'(a), pat(a), 4'hF, 1'b0, 4'd0, 1'b0);
            step("fill", 1'b0, 32'h0);
        end
        drive(1'b1, 4'd2, 32'h5, 4'hF, 1'b1, 4'd2, 1'b1);
        step("initreq", 1'b1, BYP ? 32'h5 : pat(2));
        check("initreq busy", 32'(init_busy), 32'h1);
        drive(1'b1, 4'd0, 32'h00000BAD, 4'hF, 1'b1, 4'd0, 1'b0);
        n = 1;
        while (n < 100) begin
            init_req = (n == 8);
            step("reinit", 1'b0, 32'h0);
            if (!init_busy) break;
            n++;
        end
        check("reinit busy cycles", 32'(n), 32'd16);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0);
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a), 1'b0);
            step("sweep1", 1'b1, INIT_VAL);
        end

        // Reset part-way through a sweep
        drive(1'b1, 4'd4, 32'h13579BDF, 4'hF, 1'b0, 4'd0, 1'b0);
        step("wr4", 1'b0, 32'h0);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd4, 1'b0);
        step("rd4", 1'b1, 32'h13579BDF);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b1);
        step("req2", 1'b0, 32'h0);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd4, 1'b0);
        repeat (7) step("pre", 1'b0, 32'h0);
        reset_n = 1'b0;
        #1;
        check("midrst busy", 32'(init_busy), 32'h1);
        check("midrst r_valid", 32'(r_valid), 32'h0);
        check("midrst r_data", r_data, 32'h0);
        last_data = 32'h0;
        repeat (2) step("inrst", 1'b0, 32'h0);
        reset_n = 1'b1;
        n = 0;
        while (init_busy && n < 100) begin
            n++;
            step("postrst", 1'b0, 32'h0);
        end
        check("postrst busy cycles", 32'(n), 32'd16);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd4, 1'b0);
        step("rd4 after", 1'b1, INIT_VAL);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0);
        step("idle", 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
